// File: rtl/fifo_pkt_drain_if.sv
// Port-FIFO / selector / output-stream bundle for the packet drain stage.
// The master modport is the drain itself; slave is the surrounding fabric.
`timescale 1ns/1ps
interface fifo_pkt_drain_if #(
   parameter int PORT_NUM = 6,
   parameter int DATA_W   = 32
);
   logic [7:0]                 fifo_sel_res_final;
   logic [PORT_NUM-1:0]        fifo_empty;
   logic [PORT_NUM-1:0]        fifo_eop;
   logic [PORT_NUM*DATA_W-1:0] fifo_dout;
   logic [PORT_NUM-1:0]        fifo_rd_en;
   logic                       out_valid;
   logic                       out_ready;
   logic [DATA_W-1:0]          out_data;
   logic                       out_sop;
   logic                       out_eop;
   logic [2:0]                 out_port;
   logic                       pkt_done;
   logic                       pkt_err;

   modport master (
      input  fifo_sel_res_final, fifo_empty, fifo_eop, fifo_dout, out_ready,
      output fifo_rd_en, out_valid, out_data, out_sop, out_eop, out_port,
             pkt_done, pkt_err
   );

   modport slave (
      output fifo_sel_res_final, fifo_empty, fifo_eop, fifo_dout, out_ready,
      input  fifo_rd_en, out_valid, out_data, out_sop, out_eop, out_port,
             pkt_done, pkt_err
   );
endinterface

// File: rtl/fifo_pkt_drain.sv
// Latches one granted port, drains exactly one packet from its FWFT FIFO onto a
// registered valid/ready stream, then pauses a cycle before re-arbitrating.
`timescale 1ns/1ps
module fifo_pkt_drain #(
   parameter int PORT_NUM  = 6,
   parameter int DATA_W    = 32,
   parameter int MAX_WORDS = 1024
) (
   input logic              glb_clk,
   input logic              glb_areset_n,
   fifo_pkt_drain_if.master bus
);
   localparam int CNT_W = $clog2(MAX_WORDS + 1);

   typedef enum logic [1:0] {IDLE, XFER, FLUSH, DONE} state_t;

   state_t              r_state;
   logic [2:0]          r_cur_port;
   logic [CNT_W-1:0]    r_word_cnt;
   logic                r_out_valid;
   logic [DATA_W-1:0]   r_out_data;
   logic                r_out_sop;
   logic                r_out_eop;
   logic [2:0]          r_out_port;
   logic                r_pkt_done;
   logic                r_pkt_err;

   logic                w_head_empty;
   logic                w_head_eop;
   logic [DATA_W-1:0]   w_head_data;
   logic                w_pop;
   logic                w_last;
   logic                w_sel_ok;
   logic [PORT_NUM-1:0] w_rd_en;
   logic                w_unused;

   // NOTE: every combinational output gets a default before the loop so no path leaves it unassigned (no latch).
   always_comb begin
      w_head_empty = 1'b1;
      w_head_eop   = 1'b0;
      w_head_data  = '0;
      for (int p = 0; p < PORT_NUM; p++) begin
         if (r_cur_port == 3'(p)) begin
            w_head_empty = bus.fifo_empty[p];
            w_head_eop   = bus.fifo_eop[p];
            w_head_data  = bus.fifo_dout[p*DATA_W +: DATA_W];
         end
      end
   end

   assign w_pop    = (r_state == XFER) && !w_head_empty && (!r_out_valid || bus.out_ready);
   // The watchdog closes the packet on the last permitted word even without a head EOP.
   assign w_last   = w_head_eop || (r_word_cnt == CNT_W'(MAX_WORDS - 1));
   assign w_sel_ok = bus.fifo_sel_res_final[7] && (int'(bus.fifo_sel_res_final[2:0]) < PORT_NUM);
   assign w_unused = ^bus.fifo_sel_res_final[6:3];

   always_comb begin
      w_rd_en = '0;
      for (int p = 0; p < PORT_NUM; p++) begin
         w_rd_en[p] = w_pop && (r_cur_port == 3'(p));
      end
   end

   assign bus.fifo_rd_en = w_rd_en;
   assign bus.out_valid  = r_out_valid;
   assign bus.out_data   = r_out_data;
   assign bus.out_sop    = r_out_sop;
   assign bus.out_eop    = r_out_eop;
   assign bus.out_port   = r_out_port;
   assign bus.pkt_done   = r_pkt_done;
   assign bus.pkt_err    = r_pkt_err;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge glb_clk or negedge glb_areset_n) begin
      if (!glb_areset_n) begin
         r_state     <= IDLE;
         r_cur_port  <= '0;
         r_word_cnt  <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sop   <= 1'b0;
         r_out_eop   <= 1'b0;
         r_out_port  <= '0;
         r_pkt_done  <= 1'b0;
         r_pkt_err   <= 1'b0;
      end else begin
         r_pkt_done <= 1'b0;
         r_pkt_err  <= 1'b0;

         if (w_pop) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_head_data;
            r_out_port  <= r_cur_port;
            r_out_sop   <= (r_word_cnt == '0);
            r_out_eop   <= w_last;
            r_word_cnt  <= r_word_cnt + CNT_W'(1);
         end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
         end

         case (r_state)
            IDLE: begin
               if (w_sel_ok) begin
                  r_cur_port <= bus.fifo_sel_res_final[2:0];
                  r_word_cnt <= '0;
                  r_state    <= XFER;
               end
            end
            XFER: begin
               if (w_pop && w_last) begin
                  r_pkt_err <= !w_head_eop;
                  r_state   <= FLUSH;
               end
            end
            FLUSH: begin
               if (r_out_valid && bus.out_ready) begin
                  r_pkt_done <= 1'b1;
                  r_state    <= DONE;
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
